uart_rx: RTL and testbench

//  Serial receive front end of the ACIA's UART. Samples the asynchronous rx pin at
//  16x the bit rate from an internal baud tick divider and deframes 8N1 characters.

---
 rtl/uart_rx_if.sv | 39 +++
 rtl/uart_rx.sv | 153 +++++++++++++++
 tb/tb_uart_rx.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if
//   Bundles the serial line, the baud divisor and the received-byte outputs of
//   the UART receiver so that they travel between modules as one port.
//   Signals:
//     rx            serial input, idle high (driven by master)
//     dvsr          baud divisor, tick period = dvsr+1 clk (driven by master)
//     dout          last received byte (driven by slave)
//     rx_done_tick  one-clk pulse, dout holds a new good byte (driven by slave)
//     frame_err     one-clk pulse, stop bit was sampled low (driven by slave)
//     rx_busy       receiver is working on a character (driven by slave)
//   Modports: master = line/divisor source and byte sink, slave = receiver.
interface uart_rx_if #(
  parameter int DVSR_W = 11
);
  logic              rx;
  logic [DVSR_W-1:0] dvsr;
  logic [7:0]        dout;
  logic              rx_done_tick;
  logic              frame_err;
  logic              rx_busy;

  modport master (
    output rx,
    output dvsr,
    input  dout,
    input  rx_done_tick,
    input  frame_err,
    input  rx_busy
  );

  modport slave (
    input  rx,
    input  dvsr,
    output dout,
    output rx_done_tick,
    output frame_err,
    output rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx
//   Serial receive front end of the ACIA UART. The asynchronous rx line is
//   synchronised, oversampled at 16x the bit rate from an internal baud tick
//   divider and deframed as 8N1. Good bytes appear on dout with a one-clk
//   rx_done_tick (the rx FIFO write strobe); a low stop bit gives a one-clk
//   frame_err instead. Start-bit glitches shorter than half a bit are dropped.
//   Ports:
//     clk  system clock
//     rst  synchronous reset, active high
//     bus  uart_rx_if slave: rx, dvsr in; dout, rx_done_tick, frame_err,
//          rx_busy out
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR_W  = 11
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic              rxMeta_q, rxSync_q;
  logic [DVSR_W-1:0] cnt_q, cnt_d;
  logic              tick;
  logic [3:0]        s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic [7:0]        dout_q, dout_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic              busy_q, busy_d;

  // The >= compare makes a divisor lowered below the running count wrap at
  // once instead of running through the whole counter range.
  assign tick  = (cnt_q >= bus.dvsr);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      cnt_q    <= '0;
      state_q  <= IDLE;
      s_q      <= '0;
      n_q      <= '0;
      b_q      <= '0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rxMeta_q <= bus.rx;
      rxSync_q <= rxMeta_q;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      s_q      <= s_d;
      n_q      <= n_d;
      b_q      <= b_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
    end
  end

  // Leaving STOP goes straight to IDLE, which reacts to a low rx_s on the
  // very next clk, so back-to-back frames and a held break both re-enter
  // START without any idle gap.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rxSync_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == 4'd7) begin
            if (!rxSync_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == 4'd15) begin
            s_d = '0;
            b_d = {rxSync_q, b_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == 4'(SB_TICK - 1)) begin
            dout_d  = 8'(b_q);
            state_d = IDLE;
            if (rxSync_q) begin
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
  assign bus.rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
//   Directed bench for uart_rx. A table of whole 8N1 frames (divisor, data,
//   stop-bit polarity, expected pulse counts and byte) is replayed in a loop;
//   hand-written sequences cover start latency, a start glitch, back-to-back
//   frames, reset in mid-byte and a held break.
module tb_uart_rx;

  logic clk;
  logic rst;

  uart_rx_if #(.DVSR_W(11)) bus ();

  uart_rx #(
    .DBIT   (8),
    .SB_TICK(16),
    .DVSR_W (11)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] dvsr;
    logic [7:0]  data;
    logic        stopLow;
    int          expDone;
    int          expFerr;
    logic [7:0]  expDout;
  } vec_t;

  int         checksPassed = 0;
  int         checksTotal  = 0;
  int         doneCount    = 0;
  int         ferrCount    = 0;
  int         bothCount    = 0;
  logic [7:0] doneLog [0:63];

  // Pulses are counted on the falling edge, half a clock away from the edge
  // that updates them; each good byte is logged as it is announced.
  always @(negedge clk) begin
    if (bus.rx_done_tick) begin
      doneLog[doneCount % 64] = bus.dout;
      doneCount = doneCount + 1;
    end
    if (bus.frame_err) ferrCount = ferrCount + 1;
    if (bus.rx_done_tick && bus.frame_err) bothCount = bothCount + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksTotal = checksTotal + 1;
    if (actual === expected) begin
      checksPassed = checksPassed + 1;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int bitClk();
    return 16 * (int'(bus.dvsr) + 1);
  endfunction

  // Sends one 8N1 frame at the current divisor. A low stop bit is held for
  // three quarters of a bit only, so the receiver's re-entered START sees the
  // line high again at its mid-start sample and drops back to IDLE.
  task automatic applyStimulus(input logic [7:0] data, input logic stopLow);
    int bt;
    bt = bitClk();
    bus.rx = 1'b0;
    waitClk(bt);
    for (int i = 0; i < 8; i++) begin
      bus.rx = data[i];
      waitClk(bt);
    end
    if (stopLow) begin
      bus.rx = 1'b0;
      waitClk((bt * 3) / 4);
      bus.rx = 1'b1;
      waitClk(bt - (bt * 3) / 4);
    end else begin
      bus.rx = 1'b1;
      waitClk(bt);
    end
  endtask

  vec_t vecs [6];
  int   d0, f0;

  initial begin
    vecs[0] = '{dvsr: 11'd26, data: 8'h55, stopLow: 1'b0, expDone: 1, expFerr: 0, expDout: 8'h55};
    vecs[1] = '{dvsr: 11'd26, data: 8'hA3, stopLow: 1'b1, expDone: 0, expFerr: 1, expDout: 8'hA3};
    vecs[2] = '{dvsr: 11'd0,  data: 8'h81, stopLow: 1'b0, expDone: 1, expFerr: 0, expDout: 8'h81};
    vecs[3] = '{dvsr: 11'd5,  data: 8'hC6, stopLow: 1'b0, expDone: 1, expFerr: 0, expDout: 8'hC6};
    vecs[4] = '{dvsr: 11'd0,  data: 8'h5A, stopLow: 1'b1, expDone: 0, expFerr: 1, expDout: 8'h5A};
    vecs[5] = '{dvsr: 11'd3,  data: 8'h01, stopLow: 1'b0, expDone: 1, expFerr: 0, expDout: 8'h01};

    rst      = 1'b1;
    bus.rx   = 1'b1;
    bus.dvsr = 11'd26;
    waitClk(3);
    rst = 1'b0;
    waitClk(1);
    checkOutput("reset_dout", 32'(bus.dout), 32'h0);
    checkOutput("reset_done", 32'(bus.rx_done_tick), 32'h0);
    checkOutput("reset_ferr", 32'(bus.frame_err), 32'h0);
    checkOutput("reset_busy", 32'(bus.rx_busy), 32'h0);
    waitClk(10);

    // Start edge reaches START on the third clock; a 150-clk low is shorter
    // than the 8 ticks to mid-start and must be dropped silently.
    d0 = doneCount; f0 = ferrCount;
    bus.rx = 1'b0;
    waitClk(2);
    checkOutput("start_latency_busy_2clk", 32'(bus.rx_busy), 32'h0);
    waitClk(1);
    checkOutput("start_latency_busy_3clk", 32'(bus.rx_busy), 32'h1);
    waitClk(147);
    bus.rx = 1'b1;
    waitClk(400);
    checkOutput("glitch_busy", 32'(bus.rx_busy), 32'h0);
    checkOutput("glitch_done", 32'(doneCount - d0), 32'h0);
    checkOutput("glitch_ferr", 32'(ferrCount - f0), 32'h0);

    for (int v = 0; v < 6; v++) begin
      bus.dvsr = vecs[v].dvsr;
      waitClk(40);
      d0 = doneCount; f0 = ferrCount;
      applyStimulus(vecs[v].data, vecs[v].stopLow);
      waitClk(2 * bitClk());
      checkOutput($sformatf("vec%0d_done", v), 32'(doneCount - d0), 32'(vecs[v].expDone));
      checkOutput($sformatf("vec%0d_ferr", v), 32'(ferrCount - f0), 32'(vecs[v].expFerr));
      checkOutput($sformatf("vec%0d_dout", v), 32'(bus.dout), 32'(vecs[v].expDout));
      checkOutput($sformatf("vec%0d_busy", v), 32'(bus.rx_busy), 32'h0);
    end

    // Back-to-back frames with a single stop bit and no idle gap.
    bus.dvsr = 11'd26;
    waitClk(40);
    d0 = doneCount; f0 = ferrCount;
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'hFF, 1'b0);
    waitClk(2 * bitClk());
    checkOutput("b2b_done", 32'(doneCount - d0), 32'h2);
    checkOutput("b2b_first", 32'(doneLog[d0 % 64]), 32'h00);
    checkOutput("b2b_second", 32'(doneLog[(d0 + 1) % 64]), 32'hFF);
    checkOutput("b2b_ferr", 32'(ferrCount - f0), 32'h0);

    // Reset in mid-byte at dvsr=0: the partial character must vanish.
    bus.dvsr = 11'd0;
    waitClk(40);
    d0 = doneCount; f0 = ferrCount;
    bus.rx = 1'b0;
    waitClk(16);
    bus.rx = 1'b0;
    waitClk(16);
    bus.rx = 1'b0;
    waitClk(8);
    bus.rx = 1'b1;
    rst = 1'b1;
    waitClk(1);
    rst = 1'b0;
    checkOutput("midreset_busy", 32'(bus.rx_busy), 32'h0);
    checkOutput("midreset_dout", 32'(bus.dout), 32'h0);
    waitClk(12 * 16);
    checkOutput("midreset_no_done", 32'(doneCount - d0), 32'h0);
    checkOutput("midreset_no_ferr", 32'(ferrCount - f0), 32'h0);
    applyStimulus(8'h3C, 1'b0);
    waitClk(32);
    checkOutput("after_reset_done", 32'(doneCount - d0), 32'h1);
    checkOutput("after_reset_dout", 32'(bus.dout), 32'h3C);

    // Break: 40 bit times low at dvsr=0 repeats a 153-clk frame, so four
    // frame errors land inside the 640-clk window and no good byte.
    waitClk(40);
    d0 = doneCount; f0 = ferrCount;
    bus.rx = 1'b0;
    waitClk(40 * 16);
    checkOutput("break_ferr", 32'(ferrCount - f0), 32'h4);
    checkOutput("break_no_done", 32'(doneCount - d0), 32'h0);
    bus.rx = 1'b1;
    waitClk(12 * 16);
    checkOutput("post_break_busy", 32'(bus.rx_busy), 32'h0);
    d0 = doneCount; f0 = ferrCount;
    applyStimulus(8'h7E, 1'b0);
    waitClk(32);
    checkOutput("post_break_done", 32'(doneCount - d0), 32'h1);
    checkOutput("post_break_dout", 32'(bus.dout), 32'h7E);
    checkOutput("post_break_ferr", 32'(ferrCount - f0), 32'h0);

    checkOutput("done_ferr_never_both", 32'(bothCount), 32'h0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
